// File: rtl/mac_host_sequencer.sv
// Host-side driver for the MAC core pin protocol: turns MAC/CLEAR/READ commands
// into single-cycle strobed byte transfers and gathers READ bytes into one response.
module mac_host_sequencer #(
  parameter int RESULT_BYTES = 3,
  parameter int READ_LAT     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [7:0]                cmd_a,
  input  logic [7:0]                cmd_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [8*RESULT_BYTES-1:0] rsp_data,
  output logic [7:0]                dev_ui_in,
  output logic [7:0]                dev_uio_in,
  input  logic [7:0]                dev_uo_out,
  output logic                      busy
);

  localparam int IDX_W = 2;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESULT_BYTES - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LAT - 1);

  localparam logic [1:0] OP_MAC   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  localparam logic [1:0] DEV_LOAD_A  = 2'b00;
  localparam logic [1:0] DEV_LOAD_B  = 2'b01;
  localparam logic [1:0] DEV_CLEAR   = 2'b10;
  localparam logic [1:0] DEV_READ_BY = 2'b11;

  typedef enum logic [3:0] {
    IDLE, LD_A, GAP_A, LD_B, GAP_B, CLR, GAP_C, RD_STB, RD_WAIT, RSP
  } state_t;

  state_t                    r_state;
  state_t                    w_nxt_state;
  logic [7:0]                r_b;
  logic [IDX_W-1:0]          r_idx;
  logic [LAT_W-1:0]          r_lat;
  logic [7:0]                r_ui;
  logic [7:0]                r_uio;
  logic                      r_rsp_valid;
  logic [8*RESULT_BYTES-1:0] r_rsp_data;
  logic [7:0]                w_ui_nxt;
  logic [7:0]                w_uio_nxt;
  logic                      w_last_lat;

  // Strobe word: bit 0 strobe, [2:1] device opcode, [4:3] byte index.
  function automatic logic [7:0] fn_uio(input logic [1:0] op, input logic [IDX_W-1:0] idx);
    return {3'b000, idx, op, 1'b1};
  endfunction

  assign w_last_lat = (r_lat == LAST_LAT);

  always_comb begin
    w_nxt_state = r_state;
    w_ui_nxt    = 8'h00;
    w_uio_nxt   = 8'h00;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_MAC: begin
              w_nxt_state = LD_A;
              w_ui_nxt    = cmd_a;
              w_uio_nxt   = fn_uio(DEV_LOAD_A, '0);
            end
            OP_CLEAR: begin
              w_nxt_state = CLR;
              w_uio_nxt   = fn_uio(DEV_CLEAR, '0);
            end
            OP_READ: begin
              w_nxt_state = RD_STB;
              w_uio_nxt   = fn_uio(DEV_READ_BY, '0);
            end
            default: w_nxt_state = IDLE;
          endcase
        end
      end
      LD_A:  w_nxt_state = GAP_A;
      GAP_A: begin
        w_nxt_state = LD_B;
        w_ui_nxt    = r_b;
        w_uio_nxt   = fn_uio(DEV_LOAD_B, '0);
      end
      LD_B:   w_nxt_state = GAP_B;
      GAP_B:  w_nxt_state = IDLE;
      CLR:    w_nxt_state = GAP_C;
      GAP_C:  w_nxt_state = IDLE;
      RD_STB: w_nxt_state = RD_WAIT;
      RD_WAIT: begin
        if (w_last_lat) begin
          if (r_idx == LAST_IDX) begin
            w_nxt_state = RSP;
          end else begin
            w_nxt_state = RD_STB;
            w_uio_nxt   = fn_uio(DEV_READ_BY, r_idx + 2'd1);
          end
        end
      end
      RSP: if (rsp_ready) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_lat       <= '0;
      r_ui        <= 8'h00;
      r_uio       <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ui        <= w_ui_nxt;
      r_uio       <= w_uio_nxt;
      r_rsp_valid <= (w_nxt_state == RSP);
      if (r_state == RD_STB) begin
        r_lat <= '0;
      end else if (r_state == RD_WAIT) begin
        r_lat <= r_lat + 1'b1;
      end
      // The byte captured on the last wait cycle is the one the core has had READ_LAT cycles to present.
      if (r_state == IDLE) begin
        r_idx <= '0;
      end else if (r_state == RD_WAIT && w_last_lat) begin
        r_rsp_data[r_idx*8 +: 8] <= dev_uo_out;
        r_idx                    <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && cmd_valid) r_b <= cmd_b;
  end

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign dev_ui_in  = r_ui;
  assign dev_uio_in = r_uio;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_mac_host_sequencer.sv
// Bench for mac_host_sequencer: a behavioural MAC core answers the pin protocol,
// and expected results come from plain arithmetic over the issued commands.
module tb_mac_host_sequencer;

  localparam int RB = 3;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [7:0]    cmd_a = 8'h00;
  logic [7:0]    cmd_b = 8'h00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [8*RB-1:0] rsp_data;
  logic [7:0]    dev_ui_in;
  logic [7:0]    dev_uio_in;
  logic [7:0]    dev_uo_out;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int prot_err = 0;
  logic [8*RB-1:0] exp_acc = '0;

  mac_host_sequencer #(.RESULT_BYTES(RB), .READ_LAT(L)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .dev_ui_in(dev_ui_in),
    .dev_uio_in(dev_uio_in), .dev_uo_out(dev_uo_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural core: result byte appears exactly READ_LAT cycles after its strobe, garbage otherwise.
  logic [31:0] core_acc = 32'd0;
  logic [7:0]  core_a = 8'h00;
  logic [7:0]  core_uo = 8'h00;
  logic [7:0]  rd_byte = 8'h00;
  int          rd_cnt = 0;
  assign dev_uo_out = core_uo;

  always @(posedge clk) begin
    core_uo <= 8'($urandom);
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) core_uo <= rd_byte;
    end
    if (dev_uio_in[0]) begin
      case (dev_uio_in[2:1])
        2'b00: core_a = dev_ui_in;
        2'b01: core_acc = core_acc + 32'(core_a) * 32'(dev_ui_in);
        2'b10: core_acc = 32'd0;
        default: begin
          rd_byte = 8'(core_acc >> (8 * int'(dev_uio_in[4:3])));
          if (L == 1) core_uo <= rd_byte;
          else rd_cnt = L - 1;
        end
      endcase
    end
  end

  // Protocol monitor: gap after each strobe, ui quiet without strobe, reserved bits zero.
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0;
    end else begin
      if (prev_stb && (dev_ui_in != 8'h00 || dev_uio_in != 8'h00)) prot_err++;
      if (!dev_uio_in[0] && (dev_ui_in != 8'h00 || dev_uio_in != 8'h00)) prot_err++;
      if (dev_uio_in[7:5] != 3'b000) prot_err++;
      prev_stb = dev_uio_in[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout cmd_ready=%0b required=1", cmd_ready);
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
  endtask

  task automatic test_reset();
    int strobes = 0;
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    rsp_ready = 1'($urandom);
    repeat (3) tick();
    checks++;
    if ({dev_ui_in, dev_uio_in, rsp_valid, busy, cmd_ready} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs ui=%h uio=%h rv=%b busy=%b rdy=%b required 00 00 0 0 1",
               dev_ui_in, dev_uio_in, rsp_valid, busy, cmd_ready);
    end
    checks++;
    if (rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_rsp_data got=%h required=0", rsp_data);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b0;
    repeat (10) begin
      tick();
      if (dev_uio_in[0]) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL reset_idle_strobes got=%0d required=0", strobes);
    end
  endtask

  task automatic test_mac(input logic [7:0] a, input logic [7:0] b);
    send_cmd(2'd0, a, b);
    checks++;
    if (dev_ui_in !== a || dev_uio_in !== 8'h01 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL mac_c1 ui=%h uio=%h rdy=%b required %h 01 0", dev_ui_in, dev_uio_in, cmd_ready, a);
    end
    tick();
    checks++;
    if (dev_ui_in !== 8'h00 || dev_uio_in !== 8'h00) begin
      failures++;
      $display("FAIL mac_c2 ui=%h uio=%h required 00 00", dev_ui_in, dev_uio_in);
    end
    tick();
    checks++;
    if (dev_ui_in !== b || dev_uio_in !== 8'h03) begin
      failures++;
      $display("FAIL mac_c3 ui=%h uio=%h required %h 03", dev_ui_in, dev_uio_in, b);
    end
    tick();
    checks++;
    if (dev_ui_in !== 8'h00 || dev_uio_in !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mac_c4 ui=%h uio=%h busy=%b required 00 00 1", dev_ui_in, dev_uio_in, busy);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mac_c5_ready got=%b required=1", cmd_ready);
    end
    exp_acc = exp_acc + (8*RB)'(16'(a) * 16'(b));
  endtask

  task automatic test_clear();
    send_cmd(2'd1, 8'($urandom), 8'($urandom));
    checks++;
    if (dev_ui_in !== 8'h00 || dev_uio_in !== 8'h05) begin
      failures++;
      $display("FAIL clear_c1 ui=%h uio=%h required 00 05", dev_ui_in, dev_uio_in);
    end
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_c3_ready got=%b required=1", cmd_ready);
    end
    exp_acc = '0;
  endtask

  task automatic test_read(input int hold);
    logic [7:0] e;
    logic [8*RB-1:0] snap;
    send_cmd(2'd2, 8'($urandom), 8'($urandom));
    for (int c = 1; c <= RB * (L + 1); c++) begin
      e = ((c - 1) % (L + 1) == 0) ? (8'h07 | 8'(((c - 1) / (L + 1)) << 3)) : 8'h00;
      checks++;
      if (dev_uio_in !== e || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL read_c%0d uio=%h rv=%b required %h 0", c, dev_uio_in, rsp_valid, e);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_acc) begin
      failures++;
      $display("FAIL read_rsp rv=%b data=%h required 1 %h", rsp_valid, rsp_data, exp_acc);
    end
    snap = rsp_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL read_hold%0d rv=%b data=%h rdy=%b required 1 %h 0", h, rsp_valid, rsp_data, cmd_ready, snap);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_release rv=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
    cmd_op = 2'd0; cmd_a = a1; cmd_b = b1; cmd_valid = 1'b1;
    tick();
    cmd_a = a2; cmd_b = b2;
    checks++;
    if (dev_ui_in !== a1 || dev_uio_in !== 8'h01) begin
      failures++;
      $display("FAIL b2b_a1 ui=%h uio=%h required %h 01", dev_ui_in, dev_uio_in, a1);
    end
    tick(); tick();
    checks++;
    if (dev_ui_in !== b1 || dev_uio_in !== 8'h03) begin
      failures++;
      $display("FAIL b2b_b1 ui=%h uio=%h required %h 03", dev_ui_in, dev_uio_in, b1);
    end
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got=%b required=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    checks++;
    if (dev_ui_in !== a2 || dev_uio_in !== 8'h01) begin
      failures++;
      $display("FAIL b2b_a2 ui=%h uio=%h required %h 01", dev_ui_in, dev_uio_in, a2);
    end
    tick(); tick();
    checks++;
    if (dev_ui_in !== b2 || dev_uio_in !== 8'h03) begin
      failures++;
      $display("FAIL b2b_b2 ui=%h uio=%h required %h 03", dev_ui_in, dev_uio_in, b2);
    end
    tick(); tick();
    exp_acc = exp_acc + (8*RB)'(16'(a1) * 16'(b1)) + (8*RB)'(16'(a2) * 16'(b2));
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    send_cmd(2'd2, 8'h00, 8'h00);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (dev_ui_in !== 8'h00 || dev_uio_in !== 8'h00 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pins ui=%h uio=%h rv=%b busy=%b rdy=%b required 00 00 0 0 1",
               dev_ui_in, dev_uio_in, rsp_valid, busy, cmd_ready);
    end
    tick(); tick();
    rst = 1'b0;
    repeat (15) begin
      tick();
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_rsp_valid cycles=%0d required=0", seen);
    end
    test_clear();
    test_read(1);
  endtask

  task automatic test_op3();
    int stb = 0;
    send_cmd(2'd3, 8'($urandom), 8'($urandom));
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL op3_ready rdy=%b busy=%b required 1 0", cmd_ready, busy);
    end
    repeat (6) begin
      if (dev_uio_in != 8'h00) stb++;
      tick();
    end
    checks++;
    if (stb != 0) begin
      failures++;
      $display("FAIL op3_uio nonzero_cycles=%0d required=0", stb);
    end
  endtask

  task automatic test_random();
    int k;
    for (int r = 0; r < 3; r++) begin
      test_clear();
      k = $urandom_range(1, 4);
      for (int m = 0; m < k; m++) test_mac(8'($urandom), 8'($urandom));
      test_read($urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    exp_acc = '0;
    test_mac(8'h03, 8'h05);
    test_read(5);
    test_clear();
    test_mac(8'hFF, 8'hFF);
    test_mac(8'hFF, 8'hFF);
    checks++;
    if (exp_acc !== 24'h01FC02) begin
      failures++;
      $display("FAIL model_ff_sum got=%h required=01fc02", exp_acc);
    end
    test_read(2);
    test_back_to_back();
    test_read(0);
    test_op3();
    test_reset_mid_read();
    test_random();
    checks++;
    if (prot_err != 0) begin
      failures++;
      $display("FAIL protocol_violations got=%0d required=0", prot_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
